// File: rtl/bvh_traversal_ctrl_if.sv
// -----------------------------------------------------------------------------
// bvh_traversal_ctrl_if
// Bundles every handshake and data bus of the BVH traversal sequencer.
//   ray_*    : incoming ray (valid/ready), origin, inverse direction, t-range
//   node_*   : node memory read strobe/address and returned node fields
//   isect_*  : registered intersector inputs, intersector hit and range_out
//   leaf_*   : leaf handshake towards the primitive stage
//   done_*   : traversal-complete handshake with overflow flag and node count
//   hit_t*   : nearest-hit feedback, present only when BVH_SHRINK_EN is defined
// Scalar layout: 24-bit values; vec2 = {y, x}, vec3 = {z, y, x},
// bbox = {max vec3, min vec3}. For ranges x = tmin, y = tmax.
// Modports: master = traversal controller, slave = surrounding environment.
// -----------------------------------------------------------------------------
interface bvh_traversal_ctrl_if #(
   parameter int NODE_AW = 16
);
   logic                ray_valid;
   logic                ray_ready;
   logic [71:0]         ray_orig;
   logic [71:0]         ray_inv_dir;
   logic [47:0]         ray_range;
   logic                node_rd_en;
   logic [NODE_AW-1:0]  node_addr;
   logic [143:0]        node_box;
   logic                node_leaf;
   logic [NODE_AW-1:0]  node_idx;
   logic [3:0]          node_cnt;
   logic [71:0]         isect_ray_orig;
   logic [71:0]         isect_inv_dir;
   logic [143:0]        isect_box;
   logic [47:0]         isect_range;
   logic                isect_hit;
   logic [47:0]         isect_range_in;
   logic                leaf_valid;
   logic                leaf_ready;
   logic [NODE_AW-1:0]  leaf_prim;
   logic [3:0]          leaf_cnt;
   logic [47:0]         leaf_range;
   logic                done_valid;
   logic                done_ready;
   logic                done_ovf;
   logic [15:0]         done_nodes;
`ifdef BVH_SHRINK_EN
   logic                hit_t_valid;
   logic [23:0]         hit_t;
`endif

   modport master (
`ifdef BVH_SHRINK_EN
      input  hit_t_valid, hit_t,
`endif
      input  ray_valid, ray_orig, ray_inv_dir, ray_range,
      input  node_box, node_leaf, node_idx, node_cnt,
      input  isect_hit, isect_range_in, leaf_ready, done_ready,
      output ray_ready, node_rd_en, node_addr,
      output isect_ray_orig, isect_inv_dir, isect_box, isect_range,
      output leaf_valid, leaf_prim, leaf_cnt, leaf_range,
      output done_valid, done_ovf, done_nodes
   );

   modport slave (
`ifdef BVH_SHRINK_EN
      output hit_t_valid, hit_t,
`endif
      output ray_valid, ray_orig, ray_inv_dir, ray_range,
      output node_box, node_leaf, node_idx, node_cnt,
      output isect_hit, isect_range_in, leaf_ready, done_ready,
      input  ray_ready, node_rd_en, node_addr,
      input  isect_ray_orig, isect_inv_dir, isect_box, isect_range,
      input  leaf_valid, leaf_prim, leaf_cnt, leaf_range,
      input  done_valid, done_ovf, done_nodes
   );
endinterface

// File: rtl/bvh_traversal_ctrl.sv
// -----------------------------------------------------------------------------
// bvh_traversal_ctrl
// Per-ray BVH traversal sequencer. Accepts one ray, walks the tree from node 0,
// presents each node bbox plus the current t-range to the intersector, keeps
// right children on an internal stack, emits hit leaves and reports completion.
// Ports:
//   sysclk : clock, all state on the rising edge
//   rst    : synchronous active-high reset, aborts any ray in flight
//   bus    : bvh_traversal_ctrl_if.master (ray, node memory, intersector,
//            leaf and done channels)
// Optional feature: macro BVH_SHRINK_EN adds hit_t_valid/hit_t, which shrink
// the ray tmax to the nearest reported hit so later tests cull farther nodes.
// Without it the t-range stays equal to ray_range for the whole ray.
// -----------------------------------------------------------------------------
module bvh_traversal_ctrl #(
   parameter int NODE_AW     = 16,
   parameter int STACK_DEPTH = 16,
   parameter int NODE_RD_LAT = 2
) (
   input  logic                  sysclk,
   input  logic                  rst,
   bvh_traversal_ctrl_if.master  bus
);
   localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
   localparam int LAT_W = $clog2(NODE_RD_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_TEST, S_LEAF, S_POP, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [SP_W-1:0]      sp_q, sp_d;
   logic [LAT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [47:0]          cur_range_q, cur_range_d;
   logic                 hold_leaf_q, hold_leaf_d;
   logic [NODE_AW-1:0]   hold_idx_q, hold_idx_d;
   logic [3:0]           hold_cnt_q, hold_cnt_d;
   logic                 ray_ready_q, ray_ready_d;
   logic                 node_rd_en_q, node_rd_en_d;
   logic [NODE_AW-1:0]   node_addr_q, node_addr_d;
   logic [71:0]          isect_orig_q, isect_orig_d;
   logic [71:0]          isect_inv_q, isect_inv_d;
   logic [143:0]         isect_box_q, isect_box_d;
   logic [47:0]          isect_range_q, isect_range_d;
   logic                 leaf_valid_q, leaf_valid_d;
   logic [NODE_AW-1:0]   leaf_prim_q, leaf_prim_d;
   logic [3:0]           leaf_cnt_q, leaf_cnt_d;
   logic [47:0]          leaf_range_q, leaf_range_d;
   logic                 done_valid_q, done_valid_d;
   logic                 ovf_q, ovf_d;
   logic [15:0]          nodes_q, nodes_d;
   logic [NODE_AW-1:0]   stack_q [STACK_DEPTH];
   logic                 push_s;
   logic [SP_W-1:0]      sp_m1_s;

   assign sp_m1_s = sp_q - SP_W'(1);

   // Next-state, datapath and registered-output computation for the sequencer.
   always_comb begin
      state_d       = state_q;
      sp_d          = sp_q;
      wait_cnt_d    = wait_cnt_q;
      cur_range_d   = cur_range_q;
      hold_leaf_d   = hold_leaf_q;
      hold_idx_d    = hold_idx_q;
      hold_cnt_d    = hold_cnt_q;
      ray_ready_d   = ray_ready_q;
      node_rd_en_d  = 1'b0;
      node_addr_d   = node_addr_q;
      isect_orig_d  = isect_orig_q;
      isect_inv_d   = isect_inv_q;
      isect_box_d   = isect_box_q;
      isect_range_d = isect_range_q;
      leaf_valid_d  = leaf_valid_q;
      leaf_prim_d   = leaf_prim_q;
      leaf_cnt_d    = leaf_cnt_q;
      leaf_range_d  = leaf_range_q;
      done_valid_d  = done_valid_q;
      ovf_d         = ovf_q;
      nodes_d       = nodes_q;
      push_s        = 1'b0;

`ifdef BVH_SHRINK_EN
      // A nearer hit tightens tmax; the IDLE branch below overrides this, so a
      // hit reported while idle or on the accept cycle is ignored.
      if (bus.hit_t_valid && (bus.hit_t < cur_range_q[47:24])) begin
         cur_range_d[47:24] = bus.hit_t;
      end else begin
         cur_range_d = cur_range_q;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.ray_valid && ray_ready_q) begin
               isect_orig_d = bus.ray_orig;
               isect_inv_d  = bus.ray_inv_dir;
               cur_range_d  = bus.ray_range;
               ovf_d        = 1'b0;
               nodes_d      = 16'd0;
               node_addr_d  = {NODE_AW{1'b0}};
               node_rd_en_d = 1'b1;
               ray_ready_d  = 1'b0;
               state_d      = S_FETCH;
            end else begin
               cur_range_d  = cur_range_q;
            end
         end
         S_FETCH: begin
            wait_cnt_d = {LAT_W{1'b0}};
            // With single-cycle memory the node fields are captured straight away.
            if (NODE_RD_LAT == 1) begin
               isect_box_d   = bus.node_box;
               hold_leaf_d   = bus.node_leaf;
               hold_idx_d    = bus.node_idx;
               hold_cnt_d    = bus.node_cnt;
               isect_range_d = cur_range_d;
               state_d       = S_TEST;
            end else begin
               state_d       = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q == LAT_W'(NODE_RD_LAT - 2)) begin
               isect_box_d   = bus.node_box;
               hold_leaf_d   = bus.node_leaf;
               hold_idx_d    = bus.node_idx;
               hold_cnt_d    = bus.node_cnt;
               isect_range_d = cur_range_d;
               state_d       = S_TEST;
            end else begin
               wait_cnt_d    = wait_cnt_q + LAT_W'(1);
            end
         end
         S_TEST: begin
            nodes_d = (nodes_q == 16'hFFFF) ? nodes_q : nodes_q + 16'd1;
            if (!bus.isect_hit) begin
               state_d      = S_POP;
            end else if (hold_leaf_q) begin
               leaf_valid_d = 1'b1;
               leaf_prim_d  = hold_idx_q;
               leaf_cnt_d   = hold_cnt_q;
               leaf_range_d = bus.isect_range_in;
               state_d      = S_LEAF;
            end else begin
               // Right child is deferred; on a full stack it is lost and flagged.
               if (sp_q == SP_W'(STACK_DEPTH)) begin
                  ovf_d  = 1'b1;
               end else begin
                  push_s = 1'b1;
                  sp_d   = sp_q + SP_W'(1);
               end
               node_addr_d  = hold_idx_q;
               node_rd_en_d = 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_LEAF: begin
            if (bus.leaf_ready) begin
               leaf_valid_d = 1'b0;
               state_d      = S_POP;
            end else begin
               leaf_valid_d = 1'b1;
            end
         end
         S_POP: begin
            if (sp_q == {SP_W{1'b0}}) begin
               done_valid_d = 1'b1;
               state_d      = S_DONE;
            end else begin
               node_addr_d  = stack_q[sp_m1_s[SP_W-2:0]];
               sp_d         = sp_m1_s;
               node_rd_en_d = 1'b1;
               state_d      = S_FETCH;
            end
         end
         S_DONE: begin
            if (bus.done_ready) begin
               done_valid_d = 1'b0;
               ray_ready_d  = 1'b1;
               state_d      = S_IDLE;
            end else begin
               done_valid_d = 1'b1;
            end
         end
         default: begin
            ray_ready_d  = 1'b1;
            leaf_valid_d = 1'b0;
            done_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sp_q          <= {SP_W{1'b0}};
         wait_cnt_q    <= {LAT_W{1'b0}};
         cur_range_q   <= 48'd0;
         hold_leaf_q   <= 1'b0;
         hold_idx_q    <= {NODE_AW{1'b0}};
         hold_cnt_q    <= 4'd0;
         ray_ready_q   <= 1'b1;
         node_rd_en_q  <= 1'b0;
         node_addr_q   <= {NODE_AW{1'b0}};
         isect_orig_q  <= 72'd0;
         isect_inv_q   <= 72'd0;
         isect_box_q   <= 144'd0;
         isect_range_q <= 48'd0;
         leaf_valid_q  <= 1'b0;
         leaf_prim_q   <= {NODE_AW{1'b0}};
         leaf_cnt_q    <= 4'd0;
         leaf_range_q  <= 48'd0;
         done_valid_q  <= 1'b0;
         ovf_q         <= 1'b0;
         nodes_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         sp_q          <= sp_d;
         wait_cnt_q    <= wait_cnt_d;
         cur_range_q   <= cur_range_d;
         hold_leaf_q   <= hold_leaf_d;
         hold_idx_q    <= hold_idx_d;
         hold_cnt_q    <= hold_cnt_d;
         ray_ready_q   <= ray_ready_d;
         node_rd_en_q  <= node_rd_en_d;
         node_addr_q   <= node_addr_d;
         isect_orig_q  <= isect_orig_d;
         isect_inv_q   <= isect_inv_d;
         isect_box_q   <= isect_box_d;
         isect_range_q <= isect_range_d;
         leaf_valid_q  <= leaf_valid_d;
         leaf_prim_q   <= leaf_prim_d;
         leaf_cnt_q    <= leaf_cnt_d;
         leaf_range_q  <= leaf_range_d;
         done_valid_q  <= done_valid_d;
         ovf_q         <= ovf_d;
         nodes_q       <= nodes_d;
      end
   end

   // Traversal stack storage; validity is tracked solely by sp_q.
   always_ff @(posedge sysclk) begin
      if (push_s) begin
         stack_q[sp_q[SP_W-2:0]] <= hold_idx_q + NODE_AW'(1);
      end else begin
         stack_q[sp_q[SP_W-2:0]] <= stack_q[sp_q[SP_W-2:0]];
      end
   end

   assign bus.ray_ready      = ray_ready_q;
   assign bus.node_rd_en     = node_rd_en_q;
   assign bus.node_addr      = node_addr_q;
   assign bus.isect_ray_orig = isect_orig_q;
   assign bus.isect_inv_dir  = isect_inv_q;
   assign bus.isect_box      = isect_box_q;
   assign bus.isect_range    = isect_range_q;
   assign bus.leaf_valid     = leaf_valid_q;
   assign bus.leaf_prim      = leaf_prim_q;
   assign bus.leaf_cnt       = leaf_cnt_q;
   assign bus.leaf_range     = leaf_range_q;
   assign bus.done_valid     = done_valid_q;
   assign bus.done_ovf       = ovf_q;
   assign bus.done_nodes     = nodes_q;
endmodule

// File: tb/tb_bvh_traversal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bvh_traversal_ctrl
// Directed bench: stubbed node memory (1 registered stage, NODE_RD_LAT=2) and
// intersector (hit keyed by node_addr), STACK_DEPTH=2 so a short chain overflows.
// -----------------------------------------------------------------------------
module tb_bvh_traversal_ctrl;
   logic sysclk = 1'b0;
   logic rst    = 1'b1;
   int   checks = 0;
   int   errors = 0;

   bvh_traversal_ctrl_if #(.NODE_AW(16)) bus ();

   bvh_traversal_ctrl #(.NODE_AW(16), .STACK_DEPTH(2), .NODE_RD_LAT(2)) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   // node memory and intersector stubs
   logic        tbl_hit  [16];
   logic        tbl_leaf [16];
   logic [15:0] tbl_idx  [16];
   logic [3:0]  tbl_cnt  [16];
   logic [3:0]  rd_addr_q;

   always @(posedge sysclk) begin
      if (bus.node_rd_en) rd_addr_q <= bus.node_addr[3:0];
   end
   assign bus.node_box       = {140'd0, rd_addr_q};
   assign bus.node_leaf      = tbl_leaf[rd_addr_q];
   assign bus.node_idx       = tbl_idx[rd_addr_q];
   assign bus.node_cnt       = tbl_cnt[rd_addr_q];
   assign bus.isect_hit      = tbl_hit[bus.node_addr[3:0]];
   assign bus.isect_range_in = {24'h000F00 + {20'd0, bus.node_addr[3:0]}, 24'h000001};

   // per-ray observations
   int          rd_n, leaf_n, done_cyc, leaf_vcyc, leaf_unstable;
   logic        got_done, got_ovf;
   logic [15:0] got_nodes;
   logic [15:0] rd_log   [16];
   logic [15:0] lp_log   [8];
   logic [3:0]  lc_log   [8];
   logic [47:0] lr_log   [8];
   logic        shrink_arm;

   task automatic clear_tables();
      for (int i = 0; i < 16; i++) begin
         tbl_hit[i] = 1'b0; tbl_leaf[i] = 1'b1; tbl_idx[i] = 16'd0; tbl_cnt[i] = 4'd0;
      end
   endtask

   task automatic set_node(input int a, input logic hit, input logic leaf,
                           input logic [15:0] idx, input logic [3:0] cnt);
      tbl_hit[a] = hit; tbl_leaf[a] = leaf; tbl_idx[a] = idx; tbl_cnt[a] = cnt;
   endtask

   // offer a ray at a negedge; returns at the negedge just after the accept edge
   task automatic send_ray(input logic [47:0] range);
      bus.ray_orig    = 72'h000011_000022_000033;
      bus.ray_inv_dir = 72'h000044_000055_000066;
      bus.ray_range   = range;
      bus.ray_valid   = 1'b1;
      @(negedge sysclk);
      bus.ray_valid   = 1'b0;
   endtask

   // drive leaf/done ready and record activity until done completes or budget runs out
   task automatic run_ray(input int hold);
      int          wait_n;
      logic [15:0] p0;
      logic [3:0]  c0;
      logic [47:0] r0;
      rd_n = 0; leaf_n = 0; done_cyc = 0; leaf_vcyc = 0; leaf_unstable = 0;
      got_done = 1'b0; wait_n = 0; p0 = 16'd0; c0 = 4'd0; r0 = 48'd0;
      for (int c = 1; c <= 300 && !got_done; c++) begin
`ifdef BVH_SHRINK_EN
         bus.hit_t_valid = 1'b0;
         if (shrink_arm && bus.leaf_valid) begin
            bus.hit_t_valid = 1'b1; bus.hit_t = 24'h000800; shrink_arm = 1'b0;
         end
`endif
         if (bus.node_rd_en) begin
            if (rd_n < 16) rd_log[rd_n] = bus.node_addr;
            rd_n++;
         end
         bus.leaf_ready = 1'b0;
         if (bus.leaf_valid) begin
            leaf_vcyc++;
            if (wait_n == 0) begin
               p0 = bus.leaf_prim; c0 = bus.leaf_cnt; r0 = bus.leaf_range;
            end else if (bus.leaf_prim !== p0 || bus.leaf_cnt !== c0 || bus.leaf_range !== r0) begin
               leaf_unstable++;
            end
            if (wait_n < hold) begin
               wait_n++;
            end else begin
               bus.leaf_ready = 1'b1;
               if (leaf_n < 8) begin
                  lp_log[leaf_n] = bus.leaf_prim; lc_log[leaf_n] = bus.leaf_cnt;
                  lr_log[leaf_n] = bus.leaf_range;
               end
               leaf_n++;
               wait_n = 0;
            end
         end
         if (bus.done_valid) begin
            got_done = 1'b1; done_cyc = c; got_ovf = bus.done_ovf; got_nodes = bus.done_nodes;
            bus.done_ready = 1'b1;
         end
         @(negedge sysclk);
      end
      bus.done_ready = 1'b0;
      bus.leaf_ready = 1'b0;
`ifdef BVH_SHRINK_EN
      bus.hit_t_valid = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge sysclk);
      checks++; if (bus.ray_ready !== 1'b1) begin errors++; $display("FAIL reset_ray_ready got %b exp 1", bus.ray_ready); end
      checks++; if (bus.node_rd_en !== 1'b0 || bus.leaf_valid !== 1'b0 || bus.done_valid !== 1'b0) begin
         errors++; $display("FAIL reset_strobes got rd=%b leaf=%b done=%b exp 0", bus.node_rd_en, bus.leaf_valid, bus.done_valid); end
      checks++; if (bus.done_ovf !== 1'b0 || bus.done_nodes !== 16'd0) begin
         errors++; $display("FAIL reset_done_info got ovf=%b nodes=%0d exp 0", bus.done_ovf, bus.done_nodes); end
      checks++; if (bus.isect_range !== 48'd0 || bus.leaf_prim !== 16'd0 || bus.isect_box !== 144'd0) begin
         errors++; $display("FAIL reset_data got range=%h prim=%h exp 0", bus.isect_range, bus.leaf_prim); end
      rst = 1'b0;
      @(negedge sysclk);
   endtask

   task automatic test_root_miss();
      clear_tables();
      send_ray({24'h000200, 24'h000001});
      run_ray(0);
      checks++; if (!got_done || done_cyc != 5) begin errors++; $display("FAIL miss_latency got done=%b cyc=%0d exp 5", got_done, done_cyc); end
      checks++; if (rd_n != 1 || rd_log[0] !== 16'd0) begin errors++; $display("FAIL miss_reads got n=%0d a0=%0d exp 1 read at 0", rd_n, rd_log[0]); end
      checks++; if (leaf_n != 0 || got_nodes !== 16'd1 || got_ovf !== 1'b0) begin
         errors++; $display("FAIL miss_result got leaves=%0d nodes=%0d ovf=%b exp 0/1/0", leaf_n, got_nodes, got_ovf); end
      checks++; if (bus.isect_ray_orig !== 72'h000011_000022_000033 || bus.isect_inv_dir !== 72'h000044_000055_000066) begin
         errors++; $display("FAIL miss_ray_fwd got %h %h", bus.isect_ray_orig, bus.isect_inv_dir); end
      checks++; if (bus.ray_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
         errors++; $display("FAIL miss_idle got ready=%b done=%b exp 1/0", bus.ray_ready, bus.done_valid); end
   endtask

   task automatic test_root_leaf();
      clear_tables();
      set_node(0, 1'b1, 1'b1, 16'd7, 4'd3);
      send_ray({24'h000300, 24'h000002});
      run_ray(4);
      checks++; if (leaf_n != 1 || lp_log[0] !== 16'd7 || lc_log[0] !== 4'd3) begin
         errors++; $display("FAIL leaf_fields got n=%0d prim=%0d cnt=%0d exp 1/7/3", leaf_n, lp_log[0], lc_log[0]); end
      checks++; if (lr_log[0] !== {24'h000F00, 24'h000001}) begin errors++; $display("FAIL leaf_range got %h exp 000f00000001", lr_log[0]); end
      checks++; if (leaf_vcyc != 5 || leaf_unstable != 0) begin
         errors++; $display("FAIL leaf_hold got vcyc=%0d unstable=%0d exp 5/0", leaf_vcyc, leaf_unstable); end
      checks++; if (!got_done || got_nodes !== 16'd1) begin errors++; $display("FAIL leaf_nodes got done=%b nodes=%0d exp 1", got_done, got_nodes); end
   endtask

   task automatic two_level_tree();
      clear_tables();
      set_node(0, 1'b1, 1'b0, 16'd1, 4'd0);
      set_node(1, 1'b1, 1'b1, 16'd10, 4'd1);
      set_node(2, 1'b1, 1'b1, 16'd20, 4'd0);
   endtask

   task automatic test_two_level();
      two_level_tree();
      send_ray({24'h000400, 24'h000003});
      run_ray(0);
      checks++; if (rd_n != 3 || rd_log[0] !== 16'd0 || rd_log[1] !== 16'd1 || rd_log[2] !== 16'd2) begin
         errors++; $display("FAIL two_reads got n=%0d %0d,%0d,%0d exp 0,1,2", rd_n, rd_log[0], rd_log[1], rd_log[2]); end
      checks++; if (leaf_n != 2 || lp_log[0] !== 16'd10 || lp_log[1] !== 16'd20 || lc_log[0] !== 4'd1 || lc_log[1] !== 4'd0) begin
         errors++; $display("FAIL two_leaves got n=%0d prim %0d,%0d cnt %0d,%0d exp 10,20 1,0", leaf_n, lp_log[0], lp_log[1], lc_log[0], lc_log[1]); end
      checks++; if (!got_done || got_nodes !== 16'd3 || got_ovf !== 1'b0) begin
         errors++; $display("FAIL two_done got nodes=%0d ovf=%b exp 3/0", got_nodes, got_ovf); end
      checks++; if (bus.isect_box !== 144'd2 || bus.isect_range !== {24'h000400, 24'h000003}) begin
         errors++; $display("FAIL two_isect got box=%h range=%h", bus.isect_box, bus.isect_range); end
   endtask

   task automatic test_overflow();
      clear_tables();
      set_node(0, 1'b1, 1'b0, 16'd1, 4'd0);
      set_node(1, 1'b1, 1'b0, 16'd3, 4'd0);
      set_node(3, 1'b1, 1'b0, 16'd5, 4'd0);
      set_node(5, 1'b1, 1'b0, 16'd7, 4'd0);
      set_node(7, 1'b1, 1'b1, 16'd70, 4'd1);
      set_node(4, 1'b1, 1'b1, 16'd40, 4'd2);
      set_node(2, 1'b1, 1'b1, 16'd20, 4'd3);
      set_node(6, 1'b1, 1'b1, 16'd60, 4'd4);
      set_node(8, 1'b1, 1'b1, 16'd80, 4'd5);
      send_ray({24'h000500, 24'h000004});
      run_ray(0);
      checks++; if (!got_done || got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got done=%b ovf=%b exp 1/1", got_done, got_ovf); end
      checks++; if (rd_n != 7 || rd_log[3] !== 16'd5 || rd_log[4] !== 16'd7 || rd_log[5] !== 16'd4 || rd_log[6] !== 16'd2) begin
         errors++; $display("FAIL ovf_reads got n=%0d tail %0d,%0d,%0d,%0d exp 7 reads ..5,7,4,2", rd_n, rd_log[3], rd_log[4], rd_log[5], rd_log[6]); end
      checks++; if (leaf_n != 3 || lp_log[0] !== 16'd70 || lp_log[1] !== 16'd40 || lp_log[2] !== 16'd20 || got_nodes !== 16'd7) begin
         errors++; $display("FAIL ovf_leaves got n=%0d nodes=%0d exp 3 leaves 70,40,20 nodes 7", leaf_n, got_nodes); end
   endtask

   task automatic test_reset_in_wait();
      int pulses;
      two_level_tree();
      send_ray({24'h000600, 24'h000005});
      @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      rst = 1'b0;
      checks++; if (bus.ray_ready !== 1'b1 || bus.node_rd_en !== 1'b0 || bus.leaf_valid !== 1'b0 || bus.done_valid !== 1'b0) begin
         errors++; $display("FAIL wait_rst got ready=%b rd=%b leaf=%b done=%b exp 1/0/0/0", bus.ray_ready, bus.node_rd_en, bus.leaf_valid, bus.done_valid); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.node_rd_en || bus.leaf_valid || bus.done_valid) pulses++;
         @(negedge sysclk);
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL wait_rst_quiet got %0d pulses exp 0", pulses); end
      send_ray({24'h000600, 24'h000005});
      run_ray(0);
      checks++; if (!got_done || got_nodes !== 16'd3 || rd_n != 3 || leaf_n != 2) begin
         errors++; $display("FAIL wait_rst_rerun got nodes=%0d reads=%0d leaves=%0d exp 3/3/2", got_nodes, rd_n, leaf_n); end
   endtask

   task automatic test_back_to_back();
      clear_tables();
      send_ray({24'h000700, 24'h000006});
      run_ray(0);
      send_ray({24'h000800, 24'h000007});
      run_ray(0);
      checks++; if (!got_done || done_cyc != 5 || got_nodes !== 16'd1) begin
         errors++; $display("FAIL b2b got done=%b cyc=%0d nodes=%0d exp 5/1", got_done, done_cyc, got_nodes); end
      checks++; if (bus.isect_range !== {24'h000800, 24'h000007}) begin
         errors++; $display("FAIL b2b_range got %h exp 000800000007", bus.isect_range); end
   endtask

`ifdef BVH_SHRINK_EN
   task automatic test_shrink();
      two_level_tree();
      shrink_arm = 1'b1;
      send_ray({24'h100000, 24'h000000});
      run_ray(1);
      checks++; if (!got_done || bus.isect_range[47:24] !== 24'h000800) begin
         errors++; $display("FAIL shrink got done=%b tmax=%h exp 000800", got_done, bus.isect_range[47:24]); end
   endtask
`endif

   initial begin
      bus.ray_valid = 1'b0; bus.leaf_ready = 1'b0; bus.done_ready = 1'b0;
      bus.ray_orig = 72'd0; bus.ray_inv_dir = 72'd0; bus.ray_range = 48'd0;
      shrink_arm = 1'b0;
`ifdef BVH_SHRINK_EN
      bus.hit_t_valid = 1'b0; bus.hit_t = 24'd0;
`endif
      clear_tables();
      test_reset();
      test_root_miss();
      test_root_leaf();
      test_two_level();
      test_overflow();
      test_reset_in_wait();
      test_back_to_back();
`ifdef BVH_SHRINK_EN
      test_shrink();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
